// File: rtl/mux_arb_pkg.sv
// Shared limits and index helpers for the round-robin output mux.
package mux_arb_pkg;

   localparam int N_CH_MIN  = 2;
   localparam int N_CH_MAX  = 32;
   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 64;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_t;

   // Channel-index width; a 2-channel mux still needs one bit.
   function automatic int ch_width(input int n_ch);
      int w;
      w = $clog2(n_ch);
      return (w < 1) ? 1 : w;
   endfunction

   // (base + step) mod n_ch for base < n_ch and step <= n_ch, without a divider.
   function automatic int wrap_idx(input int base, input int step, input int n_ch);
      int sum;
      sum = base + step;
      if (sum >= n_ch)
         sum = sum - n_ch;
      return sum;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid channel above the last granted index.
module rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int N_CH = 16,
   localparam int CH_W = ch_width(N_CH)
) (
   input  logic [N_CH-1:0] i_valid,
   input  logic [CH_W-1:0] i_last_ch,
   output logic [N_CH-1:0] o_grant,
   output logic [CH_W-1:0] o_grant_idx,
   output logic            o_grant_any
);

   logic [CH_W-1:0] w_cand;

   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_grant_any = 1'b0;
      w_cand      = '0;
      // Walking last_ch+1 .. last_ch+N_CH visits every channel once, ending on last_ch itself.
      for (int k = 1; k <= N_CH; k++) begin
         w_cand = CH_W'(wrap_idx(int'(i_last_ch), k, N_CH));
         if (!o_grant_any && i_valid[w_cand]) begin
            o_grant_any = 1'b1;
            o_grant_idx = w_cand;
            o_grant     = {{(N_CH-1){1'b0}}, 1'b1} << w_cand;
         end
      end
   end

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel round-robin mux into a one-entry registered output stage.
// Define MUX_ARB_LOCK_EN to add the in_lock port for multi-word channel locking.
//
// state    | meaning
// ST_EMPTY | output register holds no word; a new word may always load
// ST_FULL  | output register holds a word; loads only when out_ready drains it
module mux_arb_rr
   import mux_arb_pkg::*;
#(
   parameter  int N_CH  = 16,
   parameter  int WIDTH = 32,
   localparam int CH_W  = ch_width(N_CH)
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef MUX_ARB_LOCK_EN
   input  logic [N_CH-1:0]       in_lock,
`endif
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch
);

   out_state_t       r_state;
   out_state_t       w_state_nxt;
   logic [CH_W-1:0]  r_last_ch;
   logic [WIDTH-1:0] r_out_data;
   logic [CH_W-1:0]  r_out_ch;

   logic             w_load;
   logic             w_accept;
   logic [N_CH-1:0]  w_rr_grant;
   logic [CH_W-1:0]  w_rr_idx;
   logic             w_rr_any;
   logic [N_CH-1:0]  w_grant;
   logic [CH_W-1:0]  w_idx;
   logic             w_grant_any;
   logic [WIDTH-1:0] w_ch_data [N_CH];

   for (genvar g = 0; g < N_CH; g++) begin : g_ch_data
      assign w_ch_data[g] = in_data[g*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .N_CH (N_CH)
   ) u_rr_arbiter (
      .i_valid     (in_valid),
      .i_last_ch   (r_last_ch),
      .o_grant     (w_rr_grant),
      .o_grant_idx (w_rr_idx),
      .o_grant_any (w_rr_any)
   );

`ifdef MUX_ARB_LOCK_EN
   logic r_locked;

   // While locked the grant is pinned to the last accepted channel (which is r_last_ch).
   always_comb begin
      w_grant     = w_rr_grant;
      w_idx       = w_rr_idx;
      w_grant_any = w_rr_any;
      if (r_locked) begin
         w_idx       = r_last_ch;
         w_grant_any = in_valid[r_last_ch];
         w_grant     = in_valid[r_last_ch] ? ({{(N_CH-1){1'b0}}, 1'b1} << r_last_ch) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_locked <= 1'b0;
      else if (w_accept)
         r_locked <= in_lock[w_idx];
      else if (w_load && !in_valid[r_last_ch])
         r_locked <= 1'b0;
   end
`else
   always_comb begin
      w_grant     = w_rr_grant;
      w_idx       = w_rr_idx;
      w_grant_any = w_rr_any;
   end
`endif

   assign w_load   = (r_state == ST_EMPTY) || out_ready;
   assign w_accept = w_load && w_grant_any && !reset;
   assign in_ready = w_grant & {N_CH{w_load && !reset}};

   always_comb begin
      w_state_nxt = r_state;
      if (w_load)
         w_state_nxt = w_accept ? ST_FULL : ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_last_ch  <= CH_W'(N_CH-1);
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_out_data <= w_ch_data[w_idx];
            r_out_ch   <= w_idx;
            r_last_ch  <= w_idx;
         end
      end
   end

   assign out_valid = (r_state == ST_FULL);
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;

endmodule

// File: doc/mux_arb_rr.md
MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
- REQ-001 Parameter N_CH, default 16: number of input channels, 2..32.
- REQ-002 Parameter WIDTH, default 32: data width per channel, 1..64.
- REQ-003 Localparam CH_W = max(1, clog2(N_CH)): channel-index width.
- REQ-004 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
- REQ-005 Port reset, input, 1: reset is synchronous and active-high.
- REQ-006 Port in_valid, input, N_CH: bit i asserts that channel i offers data.
- REQ-007 Port in_data, input, N_CH*WIDTH: channel i data is bits [i*WIDTH +: WIDTH].
- REQ-008 Port in_ready, output, N_CH: bit i asserts that channel i is accepted this cycle.
- REQ-009 Port out_valid, output, 1: the output register holds a word.
- REQ-010 Port out_ready, input, 1: the downstream consumer accepts the word.
- REQ-011 Port out_data, output, WIDTH: the registered selected word.
- REQ-012 Port out_ch, output, CH_W: the index of the channel that produced out_data.
- REQ-013 Port in_lock, input, N_CH: present only with MUX_ARB_LOCK_EN (see REQ-031).

Function
- REQ-014 The block SHALL select one valid channel per cycle and register its data and index into a one-entry output stage.
- REQ-015 Latency is 1 cycle from acceptance (in_valid[i] & in_ready[i]) to out_valid.
- REQ-016 Define load = !out_valid | out_ready; the output stage SHALL accept a new word only when load is 1.
- REQ-017 in_ready SHALL be one-hot or zero; in_ready[i] = load & grant[i].
- REQ-018 grant is combinational round-robin: the first valid channel searching upward from (last_ch+1) mod N_CH, wrapping at N_CH-1 to 0.
- REQ-019 last_ch SHALL update to the granted index only on an accepted transfer; it holds otherwise.
- REQ-020 If no channel is valid and load=1, out_valid SHALL go to 0 on the next cycle (drain).
- REQ-021 A simultaneous out_ready and new acceptance SHALL replace the word with no bubble; full throughput is 1 word per cycle.
- REQ-022 While out_valid=1 and out_ready=0, out_data and out_ch SHALL hold stable and in_ready SHALL be all zero.
- REQ-023 A single continuously valid channel SHALL be granted every cycle; fairness SHALL give no channel two consecutive grants while another channel is continuously valid.
- REQ-024 A channel dropping in_valid without acceptance SHALL be legal; arbitration re-evaluates each cycle.
- REQ-025 When N_CH is not a power of two, index values >= N_CH SHALL never appear on out_ch.

Reset
- REQ-026 When reset=1 at a clock edge, out_valid=0, out_data=0, out_ch=0, and last_ch=N_CH-1, so channel 0 has first priority after reset.
- REQ-027 in_ready SHALL be all zero while reset is asserted.
- REQ-028 Reset asserted mid-transfer SHALL discard the held word without emitting it.
- REQ-029 Lock state SHALL clear on reset.

Configuration
- REQ-030 The macro MUX_ARB_LOCK_EN SHALL compile the lock feature in or out.
- REQ-031 With MUX_ARB_LOCK_EN defined: after an accepted transfer from channel i with in_lock[i]=1, the grant SHALL stay on channel i and other channels are not granted. The lock SHALL release after the first accepted transfer with in_lock[i]=0, or when in_valid[i]=0 while load=1.
- REQ-032 With MUX_ARB_LOCK_EN undefined: the in_lock port SHALL be absent and arbitration is pure round-robin.

Structure
- REQ-033 Package mux_arb_pkg SHALL hold the clog2-based CH_W helper function and the parameter limit constants.
- REQ-034 Sub-module rr_arbiter(N_CH) SHALL compute the grant vector from in_valid and last_ch; mux_arb_rr SHALL own the pointer, output register and lock.

Verification
- REQ-035 Reset scenario: reset, then in_valid=all ones with out_ready=1 -> out_ch sequence 0,1,2,...,15,0 on consecutive cycles, out_valid=1 continuously.
- REQ-036 Backpressure scenario: ch3 valid, data=0xA5A5A5A5, out_ready=0 for 5 cycles -> out_data stable at 0xA5A5A5A5, in_ready=0 after the first acceptance; raise out_ready -> one transfer, then the next word.
- REQ-037 Wrap scenario: last_ch=14, valid={15,2} -> grant 15 then 2; then only ch2 valid -> grant 2 every cycle.
- REQ-038 Drain scenario: a single word from ch7, in_valid then goes 0, out_ready=1 -> out_valid high exactly one cycle.
- REQ-039 Reset scenario: reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, and the next grant goes to the lowest valid channel.
- REQ-040 Lock scenario (MUX_ARB_LOCK_EN): ch5 sends 4 words with in_lock=1,1,1,0 while ch6 is valid -> out_ch=5,5,5,5 then 6.
